// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: fetches sequential words into a small circular FIFO
// and hands them to the core in order. A redirect flushes the queue and restarts at a new PC.
module instr_prefetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam int unsigned CNTW = PTRW + 1;
   localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

   logic [31:0]      fpc_q, fpc_d;
   logic [PTRW-1:0]  wrPtr_q, wrPtr_d;
   logic [PTRW-1:0]  rdPtr_q, rdPtr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic [31:0]      pcMem_q    [DEPTH];
   logic [31:0]      instrMem_q [DEPTH];
   logic             notEmpty;
   logic             push;
   logic             pop;

   assign notEmpty    = (count_q != '0);
   assign mem_req     = reset & (count_q < FULL) & ~redirect;
   assign mem_addr    = fpc_q;
   assign instr_valid = reset & notEmpty & ~redirect;
   // Outputs read as zero whenever the queue is empty, so they are clean straight out of reset.
   assign instr       = notEmpty ? instrMem_q[rdPtr_q] : 32'h0;
   assign instr_pc    = notEmpty ? pcMem_q[rdPtr_q]    : 32'h0;

   assign push = mem_req & mem_ack;
   assign pop  = instr_valid & instr_ready;

   always_comb begin
      fpc_d   = fpc_q;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (redirect) begin
         fpc_d   = {redirect_pc[31:2], 2'b00};
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) begin
            fpc_d   = fpc_q + 32'd4;
            wrPtr_d = wrPtr_q + 1'b1;
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpc_q   <= RESET_PC;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         fpc_q   <= fpc_d;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // push already excludes redirect cycles, so flushed data never lands in storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            pcMem_q[i]    <= 32'h0;
            instrMem_q[i] <= 32'h0;
         end
      end else if (push) begin
         pcMem_q[wrPtr_q]    <= fpc_q;
         instrMem_q[wrPtr_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: a queue-based reference model is checked every
// cycle, and hand-computed expectations pin the model at key points.
module tb_instr_prefetch;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   int vecCount  = 0;
   int missCount = 0;
   bit checkEn   = 1'b0;

   logic [31:0] qPc[$];
   logic [31:0] qIn[$];
   logic [31:0] mFpc = RPC;

   always #5 clk = ~clk;

   // Memory returns the inverted address, which makes every word traceable to its PC.
   assign mem_rdata = ~mem_addr;

   instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
   );

   function automatic bit expReq();
      return reset && (qPc.size() < DEPTH) && !redirect;
   endfunction

   function automatic bit expValid();
      return reset && (qPc.size() != 0) && !redirect;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      mem_ack     = ack;
      instr_ready = ready;
      redirect    = redir;
      redirect_pc = rpc;
   endtask

   // Reference model: the queue holds {pc, word}; transfers append, consumption removes the front.
   always @(posedge clk or negedge reset) begin : model
      bit doPush;
      bit doPop;
      if (!reset) begin
         qPc.delete();
         qIn.delete();
         mFpc <= RPC;
      end else if (redirect) begin
         qPc.delete();
         qIn.delete();
         mFpc <= {redirect_pc[31:2], 2'b00};
      end else begin
         doPush = (qPc.size() < DEPTH) && mem_ack;
         doPop  = (qPc.size() != 0) && instr_ready;
         if (doPop) begin
            void'(qPc.pop_front());
            void'(qIn.pop_front());
         end
         if (doPush) begin
            qPc.push_back(mFpc);
            qIn.push_back(~mFpc);
            mFpc <= mFpc + 32'd4;
         end
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model mem_req", {31'b0, mem_req}, {31'b0, expReq()});
         checkOutput("model mem_addr", mem_addr, reset ? mFpc : RPC);
         checkOutput("model instr_valid", {31'b0, instr_valid}, {31'b0, expValid()});
         if (!reset) begin
            checkOutput("model instr reset", instr, 32'h0);
            checkOutput("model instr_pc reset", instr_pc, 32'h0);
         end else if (expValid()) begin
            checkOutput("model instr", instr, qIn[0]);
            checkOutput("model instr_pc", instr_pc, qPc[0]);
         end
      end
   end

   initial begin
      reset       = 1'b0;
      mem_ack     = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      #2;
      checkOutput("reset mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("reset instr_valid", {31'b0, instr_valid}, 32'h0);
      checkOutput("reset instr", instr, 32'h0);
      checkOutput("reset instr_pc", instr_pc, 32'h0);
      checkOutput("reset mem_addr", mem_addr, RPC);
      checkEn = 1'b1;

      // Release between edges; first request must be visible right away.
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1;
      #2;
      checkOutput("first req", {31'b0, mem_req}, 32'h1);
      checkOutput("first addr", mem_addr, 32'h0);
      checkOutput("no bypass", {31'b0, instr_valid}, 32'h0);
      applyStimulus(1, 1, 0, 0);
      #2;
      checkOutput("first valid", {31'b0, instr_valid}, 32'h1);
      checkOutput("first pc", instr_pc, 32'h0);
      checkOutput("first instr", instr, 32'hFFFF_FFFF);
      checkOutput("second addr", mem_addr, 32'h4);
      repeat (6) applyStimulus(1, 1, 0, 0);

      // Fill to DEPTH with the core stalled, then release one slot.
      applyStimulus(0, 0, 1, 32'h0);
      repeat (4) applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      #2;
      checkOutput("full req", {31'b0, mem_req}, 32'h0);
      checkOutput("full addr", mem_addr, 32'h10);
      checkOutput("full head", instr_pc, 32'h0);
      applyStimulus(1, 1, 0, 0);
      #2;
      checkOutput("full pop req", {31'b0, mem_req}, 32'h0);
      applyStimulus(1, 0, 0, 0);
      #2;
      checkOutput("reassert req", {31'b0, mem_req}, 32'h1);
      checkOutput("reassert addr", mem_addr, 32'h10);
      checkOutput("after pop head", instr_pc, 32'h4);
      applyStimulus(1, 0, 0, 0);
      #2;
      checkOutput("refill addr", mem_addr, 32'h14);

      // Flush three queued entries; misaligned target is forced to word alignment.
      applyStimulus(0, 0, 1, 32'h0);
      repeat (3) applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 1, 32'h43);
      #2;
      checkOutput("redir valid", {31'b0, instr_valid}, 32'h0);
      checkOutput("redir req", {31'b0, mem_req}, 32'h0);
      applyStimulus(0, 1, 0, 0);
      #2;
      checkOutput("redir addr", mem_addr, 32'h40);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      #2;
      checkOutput("redir head", instr_pc, 32'h40);

      // Redirect coinciding with an acknowledged fetch of 0x8.
      applyStimulus(0, 0, 1, 32'h0);
      repeat (2) applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 1, 32'h100);
      applyStimulus(1, 1, 0, 0);
      #2;
      checkOutput("drop addr", mem_addr, 32'h100);
      applyStimulus(1, 1, 0, 0);
      #2;
      checkOutput("drop head", instr_pc, 32'h100);
      checkOutput("drop instr", instr, 32'hFFFF_FEFF);

      // Fetch PC wraps past the top of the address space.
      applyStimulus(1, 1, 1, 32'hFFFF_FFFE);
      applyStimulus(1, 1, 0, 0);
      #2;
      checkOutput("wrap addr hi", mem_addr, 32'hFFFF_FFFC);
      applyStimulus(1, 1, 0, 0);
      #2;
      checkOutput("wrap addr lo", mem_addr, 32'h0);
      checkOutput("wrap head", instr_pc, 32'hFFFF_FFFC);

      // Back-to-back redirects: the last target wins.
      applyStimulus(1, 1, 1, 32'h200);
      applyStimulus(1, 1, 1, 32'h300);
      applyStimulus(1, 1, 0, 0);
      #2;
      checkOutput("b2b addr", mem_addr, 32'h300);

      // Memory answers only every fourth cycle.
      for (int i = 0; i < 24; i++) applyStimulus((i % 4) == 3, 1, 0, 0);

      // Asynchronous reset with two entries queued.
      applyStimulus(0, 0, 1, 32'h0);
      repeat (2) applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      #1;
      checkOutput("pre-reset valid", {31'b0, instr_valid}, 32'h1);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("async req", {31'b0, mem_req}, 32'h0);
      checkOutput("async valid", {31'b0, instr_valid}, 32'h0);
      checkOutput("async pc", instr_pc, 32'h0);
      checkOutput("async addr", mem_addr, RPC);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1;
      #2;
      checkOutput("rerun addr", mem_addr, RPC);
      checkOutput("rerun req", {31'b0, mem_req}, 32'h1);
      repeat (5) applyStimulus(1, 1, 0, 0);

      @(posedge clk);
      #1;
      checkEn = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
